// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and byte width, common to the
// slave RTL and the spi_master benches.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// Pin-level SPI lines plus the byte-level tx/rx handshake of spi_slave.
interface spi_slave_if;
  import spi_pkg::*;

  logic                  ss;
  logic                  sck;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [SPI_BYTE_W-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [SPI_BYTE_W-1:0] data_out;
  logic                  new_data;
  logic                  busy;
  logic                  tx_underrun;

  modport slave (
    input  ss, sck, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, data_out, new_data, busy, tx_underrun
  );

  modport master (
    output ss, sck, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, data_out, new_data, busy, tx_underrun
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall pulses taken from the last stage against a delayed copy.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = dout & ~dly_q;
  assign fall = ~dout & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled ss/sck/mosi, MSB-first byte shifting,
// one-entry tx buffer with IDLE_BYTE substitution on underrun.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  logic ss_sync, ss_rise, ss_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .din(bus.ss),
    .dout(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .din(bus.sck),
    .dout(sck_sync), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(bus.mosi),
    .dout(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_state_e            state, state_next;
  logic [SPI_CNT_W-1:0]  bit_cnt;
  logic [SPI_BYTE_W-1:0] rx_shift;
  logic [SPI_BYTE_W-1:0] tx_shift;
  logic [SPI_BYTE_W-1:0] buf_data;
  logic                  buf_full;
  logic                  reload_pending;
  logic [SPI_BYTE_W-1:0] data_out_q;
  logic                  new_data_q;
  logic                  underrun_q;

  logic                  active;
  logic                  buf_write;
  logic                  load_now;
  logic [SPI_BYTE_W-1:0] rx_next;

  assign active    = (state == ST_SHIFT) && !ss_sync;
  assign buf_write = bus.tx_valid && !buf_full;
  // The fall after a completed byte reloads tx_shift instead of shifting it.
  assign load_now  = (state == ST_LOAD) || (active && sck_fall && reload_pending);
  assign rx_next   = {rx_shift[SPI_BYTE_W-2:0], mosi_sync};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of an always_comb gets a default first; a path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (ss_fall) state_next = ST_LOAD;
      ST_LOAD:  state_next = ss_sync ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (ss_sync) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt        <= '0;
      rx_shift       <= '0;
      tx_shift       <= '0;
      buf_data       <= '0;
      buf_full       <= 1'b0;
      reload_pending <= 1'b0;
      data_out_q     <= '0;
      new_data_q     <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      new_data_q <= 1'b0;
      underrun_q <= 1'b0;

      if (buf_write) buf_data <= bus.tx_data;

      // A write into an empty buffer during a load is kept for the next load.
      if (load_now && buf_full) buf_full <= 1'b0;
      else if (buf_write)       buf_full <= 1'b1;

      if (load_now) begin
        tx_shift       <= buf_full ? buf_data : IDLE_BYTE;
        underrun_q     <= !buf_full;
        reload_pending <= 1'b0;
      end

      if (state == ST_IDLE) begin
        bit_cnt        <= '0;
        reload_pending <= 1'b0;
      end

      if (active) begin
        if (sck_rise) begin
          rx_shift <= rx_next;
          bit_cnt  <= bit_cnt + 1'b1;
          if (bit_cnt == SPI_CNT_W'(SPI_BYTE_W - 1)) begin
            data_out_q     <= rx_next;
            new_data_q     <= 1'b1;
            reload_pending <= 1'b1;
          end
        end else if (sck_fall && !reload_pending) begin
          tx_shift <= tx_shift << 1;
        end
      end
    end
  end

  assign bus.miso        = active && tx_shift[SPI_BYTE_W-1];
  assign bus.miso_oe     = !ss_sync;
  assign bus.busy        = !ss_sync;
  assign bus.tx_ready    = !buf_full;
  assign bus.data_out    = data_out_q;
  assign bus.new_data    = new_data_q;
  assign bus.tx_underrun = underrun_q;

endmodule
